// File: rtl/gshare_pht_if.sv
// Lookup/update bundle between the IF/ID pipeline and the gshare direction predictor.
// The master side drives the lookup and correction requests; the slave is the predictor.
interface gshare_pht_if #(
  parameter int unsigned SLOTS  = 2,
  parameter int unsigned HIST_W = 8
);
  logic              ready_o;
  logic [31:0]       lk_pc_i;
  logic [SLOTS-1:0]  lk_slot_valid_i;
  logic [SLOTS-1:0]  lk_cond_i;
  logic              lk_fire_i;
  logic [SLOTS-1:0]  lk_taken_o;
  logic [HIST_W-1:0] lk_hist_o;
  logic              up_valid_i;
  logic [31:0]       up_pc_i;
  logic [HIST_W-1:0] up_hist_i;
  logic              up_taken_i;
  logic              up_mispred_i;
  logic              flush_i;

  modport master (
    input  ready_o, lk_taken_o, lk_hist_o,
    output lk_pc_i, lk_slot_valid_i, lk_cond_i, lk_fire_i,
           up_valid_i, up_pc_i, up_hist_i, up_taken_i, up_mispred_i, flush_i
  );

  modport slave (
    output ready_o, lk_taken_o, lk_hist_o,
    input  lk_pc_i, lk_slot_valid_i, lk_cond_i, lk_fire_i,
           up_valid_i, up_pc_i, up_hist_i, up_taken_i, up_mispred_i, flush_i
  );
endinterface

// File: rtl/gshare_pht.sv
// gshare conditional-branch direction predictor: 2^INDEX_W two-bit counters,
// speculative + architectural GHR with recovery, post-reset init sweep.
// Optional feature macro: GSHARE_HASH_EN (defined = gshare hashing with GHRs,
// undefined = bimodal indexing, no history registers, lk_hist_o tied to 0).
module gshare_pht #(
  parameter int unsigned INDEX_W  = 10,
  parameter int unsigned HIST_W   = 8,
  parameter int unsigned SLOTS    = 2,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input logic         clk,
  input logic         rst,
  gshare_pht_if.slave bus
);
  localparam int unsigned PHT_N = 1 << INDEX_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_d;
  logic [INDEX_W-1:0] ptr, ptr_d;
  logic               ready, ready_d;

  logic [1:0]         pht [PHT_N];

  logic [INDEX_W-1:0] lk_hist_idx;
  logic [INDEX_W-1:0] up_hist_idx;
  logic [INDEX_W-1:0] lk_idx [SLOTS];
  logic [SLOTS-1:0]   pred;

  logic               up_fire;
  logic [INDEX_W-1:0] up_idx;
  logic [1:0]         up_ctr;
  logic [1:0]         up_ctr_next;

  logic               wr_en;
  logic [INDEX_W-1:0] wr_idx;
  logic [1:0]         wr_data;

  logic               unused_pc;

  assign unused_pc = ^{bus.lk_pc_i[31:INDEX_W+2], bus.lk_pc_i[1:0],
                       bus.up_pc_i[31:INDEX_W+2], bus.up_pc_i[1:0]};

  // Per-slot lookup; slot k sits 4k bytes after slot 0, all slots share one history.
  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      lk_idx[k] = (bus.lk_pc_i[INDEX_W+1:2] + INDEX_W'(k)) ^ lk_hist_idx;
      pred[k]   = ready & bus.lk_slot_valid_i[k] & bus.lk_cond_i[k] & pht[lk_idx[k]][1];
    end
  end

  assign bus.lk_taken_o = pred;
  assign bus.ready_o    = ready;

  assign up_fire = ready & bus.up_valid_i;
  assign up_idx  = bus.up_pc_i[INDEX_W+1:2] ^ up_hist_idx;
  assign up_ctr  = pht[up_idx];

  // Saturating two-bit counter step for the resolved branch.
  always_comb begin
    up_ctr_next = up_ctr;
    if (bus.up_taken_i) begin
      if (up_ctr != 2'b11) up_ctr_next = up_ctr + 2'd1;
    end else begin
      if (up_ctr != 2'b00) up_ctr_next = up_ctr - 2'd1;
    end
  end

  // Init/run state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      ready <= ready_d;
    end
  end

  // Sweep one counter per cycle, then stay in RUN until the next reset.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    case (state)
      INIT: begin
        ptr_d = ptr + INDEX_W'(1);
        if (ptr == INDEX_W'(PHT_N - 1)) begin
          state_d = RUN;
          ptr_d   = '0;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
    ready_d = (state_d == RUN);
  end

  // Single table write port: the sweep owns it in INIT, corrections in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ptr;
    wr_data = CTR_INIT;
    if (state == INIT) begin
      wr_en = 1'b1;
    end else if (up_fire) begin
      wr_en   = 1'b1;
      wr_idx  = up_idx;
      wr_data = up_ctr_next;
    end
  end

  // Counter array; contents are defined by the sweep, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) pht[wr_idx] <= wr_data;
  end

`ifdef GSHARE_HASH_EN
  logic [HIST_W-1:0] spec_ghr, arch_ghr;
  logic [HIST_W-1:0] spec_next, arch_next, shift_ghr;
  logic              recover, stop;

  assign lk_hist_idx   = INDEX_W'(spec_ghr);
  assign up_hist_idx   = INDEX_W'(bus.up_hist_i);
  assign bus.lk_hist_o = spec_ghr;

  // Shift predicted directions of conditional slots, stopping after the first taken one.
  always_comb begin
    shift_ghr = spec_ghr;
    stop      = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (!stop && bus.lk_slot_valid_i[k] && bus.lk_cond_i[k]) begin
        shift_ghr = HIST_W'({shift_ghr, pred[k]});
        stop      = pred[k];
      end
    end
  end

  // Recovery restores the architectural view and overrides any same-cycle fire.
  always_comb begin
    arch_next = up_fire ? HIST_W'({arch_ghr, bus.up_taken_i}) : arch_ghr;
    recover   = (up_fire & bus.up_mispred_i) | bus.flush_i;
    spec_next = spec_ghr;
    if (recover)                        spec_next = arch_next;
    else if (bus.lk_fire_i && ready)    spec_next = shift_ghr;
  end

  // History registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_ghr <= '0;
      arch_ghr <= '0;
    end else begin
      spec_ghr <= spec_next;
      arch_ghr <= arch_next;
    end
  end
`else
  logic unused_hist;

  assign lk_hist_idx   = '0;
  assign up_hist_idx   = '0;
  assign bus.lk_hist_o = '0;
  assign unused_hist   = ^{bus.up_hist_i, bus.up_mispred_i, bus.flush_i, bus.lk_fire_i};
`endif

endmodule

// File: tb/tb_gshare_pht.sv
// Randomised self-checking bench for gshare_pht against a counter/history reference model.
module tb_gshare_pht;
  localparam int unsigned INDEX_W  = 10;
  localparam int unsigned HIST_W   = 8;
  localparam int unsigned SLOTS    = 2;
  localparam int unsigned PHT_N    = 1 << INDEX_W;
  localparam int          CTR_INIT = 1;
`ifdef GSHARE_HASH_EN
  localparam bit HASH = 1'b1;
`else
  localparam bit HASH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gshare_pht_if #(.SLOTS(SLOTS), .HIST_W(HIST_W)) bus ();

  gshare_pht #(
    .INDEX_W (INDEX_W),
    .HIST_W  (HIST_W),
    .SLOTS   (SLOTS),
    .CTR_INIT(2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int                m_ctr [PHT_N];
  logic [HIST_W-1:0] m_spec, m_arch;
  int                m_cnt;
  bit                m_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    else n_pass++;
  endtask

  function automatic int idx(input logic [31:0] pc, input logic [HIST_W-1:0] h);
    int i;
    i = int'((pc >> 2) % PHT_N);
    if (HASH) i = i ^ int'(h);
    return i;
  endfunction

  task automatic m_reset();
    m_cnt   = 0;
    m_ready = 1'b0;
    m_spec  = '0;
    m_arch  = '0;
  endtask

  // Compare outputs for the inputs currently applied, then advance model and DUT one cycle.
  task automatic tick();
    logic [SLOTS-1:0]  exp_t;
    logic [HIST_W-1:0] an, h;
    bit                stop;
    int                i;
    #1;
    exp_t = '0;
    for (int k = 0; k < SLOTS; k++)
      if (m_ready && bus.lk_slot_valid_i[k] && bus.lk_cond_i[k])
        exp_t[k] = (m_ctr[idx(bus.lk_pc_i + 32'(4 * k), m_spec)] >= 2);
    check("ready", 32'(bus.ready_o), 32'(m_ready));
    check("taken", 32'(bus.lk_taken_o), 32'(exp_t));
    check("hist", 32'(bus.lk_hist_o), HASH ? 32'(m_spec) : 32'd0);

    if (!m_ready) begin
      if (bus.flush_i) m_spec = m_arch;
      m_cnt++;
      if (m_cnt == int'(PHT_N)) begin
        m_ready = 1'b1;
        for (int j = 0; j < int'(PHT_N); j++) m_ctr[j] = CTR_INIT;
      end
    end else begin
      an = m_arch;
      if (bus.up_valid_i) begin
        an = HIST_W'({m_arch, bus.up_taken_i});
        i  = idx(bus.up_pc_i, bus.up_hist_i);
        if (bus.up_taken_i && m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
        else if (!bus.up_taken_i && m_ctr[i] > 0) m_ctr[i] = m_ctr[i] - 1;
      end
      if ((bus.up_valid_i && bus.up_mispred_i) || bus.flush_i) begin
        m_spec = an;
      end else if (bus.lk_fire_i) begin
        h    = m_spec;
        stop = 1'b0;
        for (int k = 0; k < SLOTS; k++)
          if (!stop && bus.lk_slot_valid_i[k] && bus.lk_cond_i[k]) begin
            h    = HIST_W'({h, exp_t[k]});
            stop = exp_t[k];
          end
        m_spec = h;
      end
      m_arch = an;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [SLOTS-1:0] v, input logic [SLOTS-1:0] c,
                       input logic fire, input logic upv, input logic [31:0] upc,
                       input logic [HIST_W-1:0] uph, input logic upt, input logic mis,
                       input logic fl);
    bus.lk_pc_i         = pc;
    bus.lk_slot_valid_i = v;
    bus.lk_cond_i       = c;
    bus.lk_fire_i       = fire;
    bus.up_valid_i      = upv;
    bus.up_pc_i         = upc;
    bus.up_hist_i       = uph;
    bus.up_taken_i      = upt;
    bus.up_mispred_i    = mis;
    bus.flush_i         = fl;
    tick();
  endtask

  task automatic rand_cycle();
    drive(32'h1000 + 32'(4 * $urandom_range(0, 15)), SLOTS'($urandom), SLOTS'($urandom),
          ($urandom_range(0, 9) < 6), 1'($urandom), 32'h1000 + 32'(4 * $urandom_range(0, 15)),
          $urandom_range(0, 1) != 0 ? m_spec : HIST_W'($urandom), 1'($urandom),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
  endtask

  task automatic check_reset();
    #1;
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_taken", 32'(bus.lk_taken_o), 32'd0);
    check("rst_hist", 32'(bus.lk_hist_o), 32'd0);
  endtask

  logic [7:0] pattern;
  logic [9:0] sat_seq;

  initial begin
    rst = 1'b0;
    m_reset();
    bus.lk_pc_i = 32'h1000; bus.lk_slot_valid_i = '1; bus.lk_cond_i = '1; bus.lk_fire_i = 1'b1;
    bus.up_valid_i = 1'b0; bus.up_pc_i = '0; bus.up_hist_i = '0; bus.up_taken_i = 1'b0;
    bus.up_mispred_i = 1'b0; bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    @(negedge clk);
    rst = 1'b1;

    // Junk traffic during the sweep must be ignored; then reset mid-sweep.
    repeat (500) rand_cycle();
    rst = 1'b0;
    check_reset();
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (PHT_N + 4) rand_cycle();

    // Freshly initialised table predicts not-taken everywhere (spec_ghr may have moved, model tracks it).
    drive(32'h1000, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
    drive(32'h1000, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);

    // Saturation: T,T,T then NT x5, then T,T; each lookup shows the previous step.
    sat_seq = 10'b1110000011;
    for (int s = 9; s >= 0; s--)
      drive(32'h1000, 2'b01, 2'b01, 1'b0, 1'b1, 32'h1000, m_spec, sat_seq[s], 1'b0, 1'b0);
    drive(32'h1000, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);

    // Read-before-write on the same entry.
    drive(32'h2000, 2'b01, 2'b01, 1'b0, 1'b1, 32'h2000, m_spec, 1'b1, 1'b0, 1'b0);
    drive(32'h2000, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);

    // Different histories at one pc: shared counter only in bimodal mode.
    drive(32'h3000, 2'b00, 2'b00, 1'b0, 1'b1, 32'h3000, 8'hAA, 1'b1, 1'b0, 1'b0);
    drive(32'h3000, 2'b00, 2'b00, 1'b0, 1'b1, 32'h3000, 8'h55, 1'b1, 1'b0, 1'b0);
    drive(32'h3000, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);

    // Build arch history 0x5A, then a taken mispredict with a concurrent fire.
    pattern = 8'h5A;
    for (int b = 7; b >= 0; b--)
      drive(32'h1000, 2'b00, 2'b00, 1'b0, 1'b1, 32'h4000, 8'h00, pattern[b], 1'b0, 1'b0);
    drive(32'h1000, 2'b11, 2'b11, 1'b1, 1'b1, 32'h4000, 8'h00, 1'b1, 1'b1, 1'b0);
    drive(32'h1000, 2'b11, 2'b11, 1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
    drive(32'h1004, 2'b11, 2'b10, 1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);

    // Flush with no update restores the architectural history.
    drive(32'h1008, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
    drive(32'h1008, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);

    repeat (3000) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
